// File: rtl/life_stepper_if.sv
// life_stepper_if
// Logic-side port of the double-buffered board memory, as seen by the
// generation engine.
//   master: the stepper. It drives the read address and the write
//           address/data/strobe, and receives read data.
//   slave : the memory. It returns read data READ_LATENCY cycles after
//           an address is presented, and commits a write on the clock
//           edge that ends a cycle with logic_wr_en high.
interface life_stepper_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int LINE_WIDTH = 8
);
    logic [LINE_WIDTH-1:0] logic_data_r;
    logic [ADDR_SIZE-1:0]  logic_addr_r;
    logic [ADDR_SIZE-1:0]  logic_addr_w;
    logic [LINE_WIDTH-1:0] logic_data_w;
    logic                  logic_wr_en;

    modport master (
        input  logic_data_r,
        output logic_addr_r,
        output logic_addr_w,
        output logic_data_w,
        output logic_wr_en
    );

    modport slave (
        output logic_data_r,
        input  logic_addr_r,
        input  logic_addr_w,
        input  logic_data_w,
        input  logic_wr_en
    );
endinterface

// File: rtl/life_stepper.sv
// life_stepper
// Computes one Game of Life generation in place on the logic-side board
// buffer. Rows are streamed through a three-row cache (prev/cur/next), so
// each row can be rewritten while its original state is still available
// to the row below it. When the last row has been written, swap_out
// pulses to publish the board to the render side.
//
// Ports:
//   clk_in      : sole clock
//   rst_in      : asynchronous active-high reset
//   step_in     : start one generation (only looked at in IDLE)
//   mem         : logic-side memory port (life_stepper_if.master)
//   swap_out    : one-cycle pulse in the final (SWAP) cycle
//   busy_out    : high from the first READ cycle through the SWAP cycle
//   dbg_state_o : current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 SWAP)
//
// Handshake: a step_in sampled high on a clock edge while IDLE starts a
// generation in the next cycle. busy_out stays high until the SWAP cycle
// ends, and swap_out is high only in that SWAP cycle. step_in is ignored,
// and not remembered, at any other time, including during SWAP.
//
// Build option: define LIFE_WRAP_EN for a toroidal board. Rows and columns
// then wrap, an extra read of the last row seeds prev_row, and a first_row
// copy of row 0 acts as next_row for the last row. Without the macro,
// cells outside the board are dead.
module life_stepper #(
    parameter int ADDR_SIZE    = 32,
    parameter int LINE_WIDTH   = 8,
    parameter int ROW_WORDS    = 4,
    parameter int NUM_ROWS     = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 step_in,
    life_stepper_if.master       mem,
    output logic                 swap_out,
    output logic                 busy_out,
    output logic [1:0]           dbg_state_o
);
    localparam int ROW_BITS = ROW_WORDS * LINE_WIDTH;
    localparam int RW_W     = $clog2(NUM_ROWS);
    localparam int CNT_W    = $clog2(ROW_WORDS + READ_LATENCY + 1);
    localparam int WI_W     = $clog2(ROW_WORDS + 1);

    localparam logic [CNT_W-1:0] ISSUE_N  = CNT_W'(ROW_WORDS);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ROW_WORDS + READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(ROW_WORDS - 1);
    localparam logic [RW_W-1:0]  LAST_ROW = RW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_SWAP} state_t;
    typedef enum logic [1:0] {T_PREV, T_CUR, T_NEXT} tgt_t;

    state_t                  state_q;
    tgt_t                    tgt_q;      // row register the current READ fills
    logic [RW_W-1:0]         row_q;      // row being (or about to be) written
    logic [RW_W-1:0]         rd_row_q;   // row being read
    logic [CNT_W-1:0]        cnt_q;      // cycle within the current phase
    logic [WI_W-1:0]         rcv_q;      // index of the next returning word
    logic [READ_LATENCY-1:0] vld_q;      // in-flight read tracker
    logic [ROW_BITS-1:0]     prev_q;
    logic [ROW_BITS-1:0]     cur_q;
    logic [ROW_BITS-1:0]     next_q;
`ifdef LIFE_WRAP_EN
    logic [ROW_BITS-1:0]     first_q;
`endif

    logic                    issue;
    logic                    land;
    logic                    wr_phase;
    logic [READ_LATENCY:0]   vld_sh;
    logic [ROW_BITS-1:0]     gen_d;      // next generation of cur_q

    assign issue    = (state_q == S_READ) && (cnt_q < ISSUE_N);
    assign land     = (state_q == S_READ) && vld_q[READ_LATENCY-1];
    assign wr_phase = (state_q == S_WRITE);
    // Appending the new issue bit below vld_q works for any latency >= 1.
    assign vld_sh   = {vld_q, issue};

    assign mem.logic_addr_r = issue ?
        ADDR_SIZE'(int'(rd_row_q) * ROW_WORDS + int'(cnt_q)) : '0;
    assign mem.logic_addr_w = wr_phase ?
        ADDR_SIZE'(int'(row_q) * ROW_WORDS + int'(cnt_q)) : '0;
    assign mem.logic_data_w = wr_phase ?
        gen_d[int'(cnt_q) * LINE_WIDTH +: LINE_WIDTH] : '0;
    assign mem.logic_wr_en  = wr_phase;
    assign swap_out         = (state_q == S_SWAP);
    assign busy_out         = (state_q != S_IDLE);
    assign dbg_state_o      = state_q;

    // Each cached row is padded with one cell on either side, so the
    // neighbourhood of column c is bits c..c+2 of the padded rows. The
    // pads hold the far edge of the row (torus) or dead cells.
    always_comb begin
        logic [ROW_BITS+1:0] ep;
        logic [ROW_BITS+1:0] ec;
        logic [ROW_BITS+1:0] en;
        logic [3:0]          n;
`ifdef LIFE_WRAP_EN
        ep = {prev_q[0], prev_q, prev_q[ROW_BITS-1]};
        ec = {cur_q[0],  cur_q,  cur_q[ROW_BITS-1]};
        en = {next_q[0], next_q, next_q[ROW_BITS-1]};
`else
        ep = {1'b0, prev_q, 1'b0};
        ec = {1'b0, cur_q,  1'b0};
        en = {1'b0, next_q, 1'b0};
`endif
        n     = '0;
        gen_d = '0;
        for (int c = 0; c < ROW_BITS; c++) begin
            n = {3'b0, ep[c]} + {3'b0, ep[c+1]} + {3'b0, ep[c+2]} +
                {3'b0, ec[c]}                   + {3'b0, ec[c+2]} +
                {3'b0, en[c]} + {3'b0, en[c+1]} + {3'b0, en[c+2]};
            gen_d[c] = (n == 4'd3) | (ec[c+1] & (n == 4'd2));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            tgt_q    <= T_CUR;
            row_q    <= '0;
            rd_row_q <= '0;
            cnt_q    <= '0;
            rcv_q    <= '0;
            vld_q    <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            next_q   <= '0;
`ifdef LIFE_WRAP_EN
            first_q  <= '0;
`endif
        end else begin
            vld_q <= vld_sh[READ_LATENCY-1:0];

            if (land) begin
                case (tgt_q)
                    T_PREV:  prev_q[int'(rcv_q) * LINE_WIDTH +: LINE_WIDTH] <= mem.logic_data_r;
                    T_CUR:   cur_q[int'(rcv_q) * LINE_WIDTH +: LINE_WIDTH]  <= mem.logic_data_r;
                    default: next_q[int'(rcv_q) * LINE_WIDTH +: LINE_WIDTH] <= mem.logic_data_r;
                endcase
`ifdef LIFE_WRAP_EN
                // Row 0 is the only row ever read into cur_row.
                if (tgt_q == T_CUR) begin
                    first_q[int'(rcv_q) * LINE_WIDTH +: LINE_WIDTH] <= mem.logic_data_r;
                end
`endif
                rcv_q <= rcv_q + WI_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (step_in) begin
                        state_q <= S_READ;
                        row_q   <= '0;
                        cnt_q   <= '0;
                        rcv_q   <= '0;
                        prev_q  <= '0;
`ifdef LIFE_WRAP_EN
                        tgt_q    <= T_PREV;
                        rd_row_q <= LAST_ROW;
`else
                        tgt_q    <= T_CUR;
                        rd_row_q <= '0;
`endif
                    end
                end

                S_READ: begin
                    if (cnt_q == RD_LAST) begin
                        cnt_q <= '0;
                        rcv_q <= '0;
                        case (tgt_q)
                            T_PREV: begin
                                tgt_q    <= T_CUR;
                                rd_row_q <= '0;
                            end
                            T_CUR: begin
                                tgt_q    <= T_NEXT;
                                rd_row_q <= RW_W'(1);
                            end
                            default: state_q <= S_WRITE;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    if (cnt_q == WR_LAST) begin
                        cnt_q  <= '0;
                        prev_q <= cur_q;
                        cur_q  <= next_q;
                        if (row_q == LAST_ROW) begin
                            state_q <= S_SWAP;
                        end else begin
                            row_q <= row_q + RW_W'(1);
                            if (row_q + RW_W'(1) < LAST_ROW) begin
                                state_q  <= S_READ;
                                tgt_q    <= T_NEXT;
                                rd_row_q <= row_q + RW_W'(2);
                            end else begin
                                // Last row needs no read: its lower
                                // neighbour is off-board or row 0.
`ifdef LIFE_WRAP_EN
                                next_q <= first_q;
`else
                                next_q <= '0;
`endif
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
